alu_issue_ctrl: RTL and testbench

Sequential issue/capture stage that sits directly in front of the 16-bit combinational ALU `my_ALU`. It accepts operation requests over a valid/ready handshake and registers the operands, carry and opcode onto the ALU inputs. After a programmable settle time it captures the ALU result and flags, and presents them downstream over a second valid/ready handshake with a sequence tag. It also cross-checks the ALU's Zer/Neg flags against the result word and keeps a completed-operation count.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_flag_check.sv | 13 +
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU issue/capture stage.
package alu_pkg;

  localparam int ALU_W = 16;
  localparam int OPC_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_flag_check.sv
// Flags the case where the ALU's Zer/Neg outputs disagree with its result word.
module alu_flag_check
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] w,
  input  logic             zer,
  input  logic             neg,
  output logic             mismatch
);

  assign mismatch = (zer != (w == '0)) || (neg != w[ALU_W-1]);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage in front of a combinational ALU: registers a request onto the
// ALU inputs, waits SETTLE cycles, captures result and flags, and holds them for downstream.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ALU_W-1:0] req_a,
  input  logic [ALU_W-1:0] req_b,
  input  logic             req_c,
  input  logic [OPC_W-1:0] req_opc,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic             alu_c,
  output logic [OPC_W-1:0] alu_opc,
  input  logic [ALU_W-1:0] alu_w,
  input  logic             alu_zer,
  input  logic             alu_neg,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ALU_W-1:0] rsp_w,
  output logic             rsp_zer,
  output logic             rsp_neg,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             flag_err,
  output logic [15:0]      op_count,
  output logic             busy
);

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ALU_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic               alu_c_q, alu_c_d;
  logic [OPC_W-1:0]   alu_opc_q, alu_opc_d;
  logic [ALU_W-1:0]   rsp_w_q, rsp_w_d;
  logic               rsp_zer_q, rsp_zer_d, rsp_neg_q, rsp_neg_d;
  logic [TAG_W-1:0]   tag_q, tag_d, next_tag_q, next_tag_d;
  logic               flag_err_q, flag_err_d;
  logic [15:0]        op_count_q, op_count_d;
  logic               accept;
  logic               mismatch;

  alu_flag_check u_flag_check (
    .w        (alu_w),
    .zer      (alu_zer),
    .neg      (alu_neg),
    .mismatch (mismatch)
  );

  // Both ports: a transfer happens on the rising edge where valid & ready are high;
  // a raised valid keeps its payload stable until that edge. Downstream may take the
  // response and upstream may hand in the next request on the same edge.
  assign req_ready = (state_q == IDLE) || ((state_q == HOLD) && rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_c_d    = alu_c_q;
    alu_opc_d  = alu_opc_q;
    rsp_w_d    = rsp_w_q;
    rsp_zer_d  = rsp_zer_q;
    rsp_neg_d  = rsp_neg_q;
    tag_d      = tag_q;
    next_tag_d = next_tag_q;
    flag_err_d = flag_err_q;
    op_count_d = op_count_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        if (cnt_q == 4'd0) begin
          rsp_w_d    = alu_w;
          rsp_zer_d  = alu_zer;
          rsp_neg_d  = alu_neg;
          flag_err_d = flag_err_q | mismatch;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
          state_d = accept ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Operands stay on the ALU after capture; only a new accept replaces them.
    if (accept) begin
      alu_a_d    = req_a;
      alu_b_d    = req_b;
      alu_c_d    = req_c;
      alu_opc_d  = req_opc;
      cnt_d      = SETTLE_M1;
      tag_d      = next_tag_q;
      next_tag_d = next_tag_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_c_q    <= 1'b0;
      alu_opc_q  <= '0;
      rsp_w_q    <= '0;
      rsp_zer_q  <= 1'b0;
      rsp_neg_q  <= 1'b0;
      tag_q      <= '0;
      next_tag_q <= '0;
      flag_err_q <= 1'b0;
      op_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_c_q    <= alu_c_d;
      alu_opc_q  <= alu_opc_d;
      rsp_w_q    <= rsp_w_d;
      rsp_zer_q  <= rsp_zer_d;
      rsp_neg_q  <= rsp_neg_d;
      tag_q      <= tag_d;
      next_tag_q <= next_tag_d;
      flag_err_q <= flag_err_d;
      op_count_q <= op_count_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_c     = alu_c_q;
  assign alu_opc   = alu_opc_q;
  assign rsp_valid = (state_q == HOLD);
  assign rsp_w     = rsp_w_q;
  assign rsp_zer   = rsp_zer_q;
  assign rsp_neg   = rsp_neg_q;
  assign rsp_tag   = tag_q;
  assign flag_err  = flag_err_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (SETTLE=1 and SETTLE=3) with ALU stubs,
// a transaction-level model, a per-cycle compare process and directed scenarios.
module tb_alu_issue_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals (index 0: SETTLE=1, index 1: SETTLE=3) ----------------
  logic        req_valid [2];
  logic        req_ready [2];
  logic [15:0] req_a     [2];
  logic [15:0] req_b     [2];
  logic        req_c     [2];
  logic [2:0]  req_opc   [2];
  logic [15:0] alu_a     [2];
  logic [15:0] alu_b     [2];
  logic        alu_c     [2];
  logic [2:0]  alu_opc   [2];
  logic [15:0] alu_w     [2];
  logic        alu_zer   [2];
  logic        alu_neg   [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_w     [2];
  logic        rsp_zer   [2];
  logic        rsp_neg   [2];
  logic [3:0]  rsp_tag   [2];
  logic        flag_err  [2];
  logic [15:0] op_count  [2];
  logic        busy      [2];
  logic        corrupt   [2];

  alu_issue_ctrl #(.SETTLE(1), .TAG_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .req_c(req_c[0]), .req_opc(req_opc[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_c(alu_c[0]), .alu_opc(alu_opc[0]),
    .alu_w(alu_w[0]), .alu_zer(alu_zer[0]), .alu_neg(alu_neg[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_w(rsp_w[0]), .rsp_zer(rsp_zer[0]), .rsp_neg(rsp_neg[0]), .rsp_tag(rsp_tag[0]),
    .flag_err(flag_err[0]), .op_count(op_count[0]), .busy(busy[0])
  );

  alu_issue_ctrl #(.SETTLE(3), .TAG_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .req_c(req_c[1]), .req_opc(req_opc[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_c(alu_c[1]), .alu_opc(alu_opc[1]),
    .alu_w(alu_w[1]), .alu_zer(alu_zer[1]), .alu_neg(alu_neg[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_w(rsp_w[1]), .rsp_zer(rsp_zer[1]), .rsp_neg(rsp_neg[1]), .rsp_tag(rsp_tag[1]),
    .flag_err(flag_err[1]), .op_count(op_count[1]), .busy(busy[1])
  );

  // ---------------- ALU stub ----------------
  function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic c, input logic [2:0] op);
    case (op)
      3'd0:    alu_fn = a + b + {15'd0, c};
      3'd1:    alu_fn = a - b;
      3'd2:    alu_fn = a & b;
      3'd3:    alu_fn = a | b;
      3'd4:    alu_fn = a ^ b;
      3'd5:    alu_fn = ~a;
      3'd6:    alu_fn = a << 1;
      default: alu_fn = b;
    endcase
  endfunction

  always_comb begin
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < 2; i++) begin
      t          = alu_fn(alu_a[i], alu_b[i], alu_c[i], alu_opc[i]);
      alu_w[i]   = t;
      alu_zer[i] = (t == 16'd0);
      alu_neg[i] = t[15] ^ corrupt[i];
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @cyc %0d: got 0x%0h, expected 0x%0h", nm, inst, cyc, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // At most one operation in flight; its response becomes visible SETTLE edges after
  // acceptance and stays until taken. A new request is taken when nothing is in flight
  // and no response is waiting, or the waiting one is taken on the same edge.
  bit          m_inflight [2];
  int          m_due      [2];
  logic [15:0] m_pw       [2];
  logic        m_pz       [2];
  logic        m_pn       [2];
  logic [3:0]  m_ptag     [2];
  bit          m_valid    [2];
  logic [15:0] m_w        [2];
  logic        m_z        [2];
  logic        m_n        [2];
  logic [3:0]  m_tag      [2];
  int          m_next_tag [2];
  logic [15:0] m_a        [2];
  logic [15:0] m_b        [2];
  logic        m_c        [2];
  logic [2:0]  m_opc      [2];
  int          m_cnt      [2];
  bit          m_err      [2];

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit can_acc(input int i);
    return !m_inflight[i] && (!m_valid[i] || rsp_ready[i]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_inflight[i] = 0; m_due[i] = 0; m_valid[i] = 0;
        m_pw[i] = '0; m_pz[i] = 0; m_pn[i] = 0; m_ptag[i] = '0;
        m_w[i] = '0; m_z[i] = 0; m_n[i] = 0; m_tag[i] = '0; m_next_tag[i] = 0;
        m_a[i] = '0; m_b[i] = '0; m_c[i] = 0; m_opc[i] = '0; m_cnt[i] = 0; m_err[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit          acc;
        logic [15:0] w;
        acc = req_valid[i] && can_acc(i);
        if (m_valid[i] && rsp_ready[i]) begin
          m_valid[i] = 0;
          if (m_cnt[i] < 65535) m_cnt[i]++;
        end
        if (m_inflight[i] && cyc == m_due[i]) begin
          m_inflight[i] = 0;
          m_valid[i] = 1;
          m_w[i] = m_pw[i]; m_z[i] = m_pz[i]; m_n[i] = m_pn[i]; m_tag[i] = m_ptag[i];
          if (m_pz[i] != (m_pw[i] == 16'd0) || m_pn[i] != m_pw[i][15]) m_err[i] = 1;
        end
        if (acc) begin
          w = alu_fn(req_a[i], req_b[i], req_c[i], req_opc[i]);
          m_pw[i] = w;
          m_pz[i] = (w == 16'd0);
          m_pn[i] = w[15] ^ corrupt[i];
          m_ptag[i] = 4'(m_next_tag[i]);
          m_next_tag[i] = (m_next_tag[i] + 1) % 16;
          m_due[i] = cyc + settle_of(i);
          m_inflight[i] = 1;
          m_a[i] = req_a[i]; m_b[i] = req_b[i]; m_c[i] = req_c[i]; m_opc[i] = req_opc[i];
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("req_ready", i, 32'(req_ready[i]), 32'(can_acc(i)));
        chk("busy",      i, 32'(busy[i]),      32'(m_inflight[i] || m_valid[i]));
        chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(m_valid[i]));
        if (m_valid[i]) begin
          chk("rsp_w",   i, 32'(rsp_w[i]),   32'(m_w[i]));
          chk("rsp_zer", i, 32'(rsp_zer[i]), 32'(m_z[i]));
          chk("rsp_neg", i, 32'(rsp_neg[i]), 32'(m_n[i]));
          chk("rsp_tag", i, 32'(rsp_tag[i]), 32'(m_tag[i]));
        end
        chk("alu_a",    i, 32'(alu_a[i]),    32'(m_a[i]));
        chk("alu_b",    i, 32'(alu_b[i]),    32'(m_b[i]));
        chk("alu_c",    i, 32'(alu_c[i]),    32'(m_c[i]));
        chk("alu_opc",  i, 32'(alu_opc[i]),  32'(m_opc[i]));
        chk("op_count", i, 32'(op_count[i]), 32'(m_cnt[i]));
        chk("flag_err", i, 32'(flag_err[i]), 32'(m_err[i]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) req_valid[i] = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic send(input int i, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [2:0] op);
    int n;
    req_a[i] = a; req_b[i] = b; req_c[i] = c; req_opc[i] = op;
    req_valid[i] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 60);
    if (!req_ready[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout[%0d]: req_ready stayed 0, expected 1", i);
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, output int at_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[i] && n < 60);
    at_cyc = cyc;
    if (!rsp_valid[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout[%0d]: rsp_valid stayed 0, expected 1", i);
    end
  endtask

  // ---------------- directed scenarios ----------------
  int t_rsp;
  int rtag  [17];
  int rtime [17];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_a[i] = '0; req_b[i] = '0; req_c[i] = 0; req_opc[i] = '0;
      rsp_ready[i] = 1; corrupt[i] = 0;
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // reset then idle
    @(negedge clk);
    chk("lit_reset_req_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("lit_reset_req_ready", 1, 32'(req_ready[1]), 32'd1);
    chk("lit_reset_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("lit_reset_busy",      0, 32'(busy[0]),      32'd0);
    chk("lit_reset_op_count",  0, 32'(op_count[0]),  32'd0);
    chk("lit_reset_flag_err",  0, 32'(flag_err[0]),  32'd0);
    chk("lit_reset_alu_a",     0, 32'(alu_a[0]),     32'd0);

    // single op, SETTLE=1: 5 + 3 = 8
    @(posedge clk); #1;
    send(0, 16'h0005, 16'h0003, 1'b0, 3'b000);
    @(negedge clk);
    chk("lit_single_alu_a",     0, 32'(alu_a[0]),     32'h0005);
    chk("lit_single_issue_vld", 0, 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    chk("lit_single_rsp_valid", 0, 32'(rsp_valid[0]), 32'd1);
    chk("lit_single_rsp_w",     0, 32'(rsp_w[0]),     32'h0008);
    chk("lit_single_rsp_tag",   0, 32'(rsp_tag[0]),   32'd0);
    @(negedge clk);
    chk("lit_single_op_count",  0, 32'(op_count[0]),  32'd1);
    chk("lit_single_after_vld", 0, 32'(rsp_valid[0]), 32'd0);

    // back-pressure with a second request pending
    reset_dut();
    rsp_ready[0] = 1'b0;
    send(0, 16'h1234, 16'h0001, 1'b0, 3'd1);
    wait_rsp(0, t_rsp);
    req_a[0] = 16'h00F0; req_b[0] = 16'h0F0F; req_c[0] = 1'b0; req_opc[0] = 3'd2;
    req_valid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("lit_bp_req_ready", 0, 32'(req_ready[0]), 32'd0);
      chk("lit_bp_rsp_w",     0, 32'(rsp_w[0]),     32'h1233);
      chk("lit_bp_rsp_tag",   0, 32'(rsp_tag[0]),   32'd0);
    end
    rsp_ready[0] = 1'b1;
    #1;
    chk("lit_bp_release_ready", 0, 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("lit_bp_op_count", 0, 32'(op_count[0]), 32'd1);
    chk("lit_bp_busy",     0, 32'(busy[0]),     32'd1);
    wait_rsp(0, t_rsp);
    chk("lit_bp_tag2", 0, 32'(rsp_tag[0]), 32'd1);
    chk("lit_bp_w2",   0, 32'(rsp_w[0]),   32'h0000);
    chk("lit_bp_zer2", 0, 32'(rsp_zer[0]), 32'd1);
    @(posedge clk); #1;

    // flag mismatch: 0x8000 reported with Neg=0
    corrupt[0] = 1'b1;
    send(0, 16'h0000, 16'h8000, 1'b0, 3'd7);
    @(negedge clk);
    chk("lit_flag_before", 0, 32'(flag_err[0]), 32'd0);
    @(negedge clk);
    chk("lit_flag_rsp_w",   0, 32'(rsp_w[0]),    32'h8000);
    chk("lit_flag_rsp_neg", 0, 32'(rsp_neg[0]),  32'd0);
    chk("lit_flag_set",     0, 32'(flag_err[0]), 32'd1);
    @(posedge clk); #1;
    corrupt[0] = 1'b0;
    send(0, 16'h7FFF, 16'h0001, 1'b0, 3'd0);
    wait_rsp(0, t_rsp);
    chk("lit_flag_sticky1", 0, 32'(flag_err[0]), 32'd1);
    chk("lit_flag_neg_ok",  0, 32'(rsp_neg[0]),  32'd1);
    @(posedge clk); #1;
    send(0, 16'hFFFF, 16'h0001, 1'b0, 3'd0);
    wait_rsp(0, t_rsp);
    chk("lit_flag_sticky2", 0, 32'(flag_err[0]), 32'd1);
    chk("lit_flag_zer_ok",  0, 32'(rsp_zer[0]),  32'd1);
    @(posedge clk); #1;

    // tag wrap, SETTLE=3, 17 back-to-back requests
    reset_dut();
    fork
      begin
        for (int k = 0; k < 17; k++)
          send(1, 16'(k * 16'h0111), 16'(16'h0101 + k), 1'(k % 2), 3'(k % 8));
      end
      begin
        for (int k = 0; k < 17; k++) begin
          wait_rsp(1, t_rsp);
          rtag[k]  = int'(rsp_tag[1]);
          rtime[k] = t_rsp;
          @(posedge clk);
        end
      end
    join
    for (int k = 0; k < 17; k++) chk("wrap_tag", k, 32'(rtag[k]), 32'(k % 16));
    chk("lit_wrap_tag15", 1, 32'(rtag[15]), 32'd15);
    chk("lit_wrap_tag16", 1, 32'(rtag[16]), 32'd0);
    for (int k = 1; k < 17; k++) chk("wrap_spacing", k, 32'(rtime[k] - rtime[k-1]), 32'd4);
    @(posedge clk); #1;

    // reset pulse during ISSUE
    send(1, 16'hABCD, 16'h0001, 1'b0, 3'd0);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("lit_abort_rsp_valid", 1, 32'(rsp_valid[1]), 32'd0);
      chk("lit_abort_alu_a",     1, 32'(alu_a[1]),     32'd0);
      chk("lit_abort_op_count",  1, 32'(op_count[1]),  32'd0);
    end
    @(posedge clk); #1;
    send(1, 16'h0002, 16'h0002, 1'b0, 3'd0);
    wait_rsp(1, t_rsp);
    chk("lit_abort_next_tag", 1, 32'(rsp_tag[1]), 32'd0);
    chk("lit_abort_next_w",   1, 32'(rsp_w[1]),   32'h0004);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
